ysyx_25050141_mem_stage: RTL and testbench
==========================================

# ysyx_25050141_mem_stage

Memory-access (ME) stage of the ysyx_25050141 RV32I core, directly downstream of the execute stage. Accepts one execute result per transaction and performs at most one aligned load or store on a single-outstanding data-memory port. Produces sign/zero-extended load data or the passed-through ALU result for write-back, with valid/ready handshakes on both sides.

## Interface
- XLEN, 32: datapath width.

- clock  in  1  stage clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  execute result present.
- in_ready  out  1  stage can accept; high only in IDLE.
- in_valE  in  XLEN  ALU result; the memory address for loads and stores.
- in_rs2_data  in  XLEN  store data.
- in_load_op  in  5  one-hot {lhu,lbu,lw,lh,lb} (bit0 = lb).
- in_store_op  in  3  one-hot {sw,sh,sb} (bit0 = sb).
- in_need_dst  in  1  instruction writes rd.
- in_sel_reg  in  1  rd result comes from load data (1) or valE (0).
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts request.
- mem_req_wen  out  1  1 = write.
- mem_req_addr  out  XLEN  word-aligned address ({valE[XLEN-1:2],2'b00}).
- mem_req_wdata  out  XLEN  lane-shifted store data.
- mem_req_wmask  out  4  byte strobes.
- mem_resp_valid  in  1  response or write acknowledge; single cycle.
- mem_resp_rdata  in  XLEN  read word.
- out_valid  out  1  write-back data present.
- out_ready  in  1  write-back accepts.
- out_result  out  XLEN  final rd value.
- out_need_dst  out  1  registered copy of in_need_dst; forced 0 on misalign.
- out_misalign  out  1  access was misaligned.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset enters IDLE. Reset clears all registers and all outputs to 0, except in_ready = 1.
- IDLE, in_valid = 1: capture all inputs.
  - No load or store op: out_result = valE; go to DONE.
  - Memory op: go to REQ.
  - Misaligned op: go directly to DONE with out_misalign = 1, out_need_dst = 0, out_result = valE, and no memory request. Misaligned means halfword with addr[0] = 1, or word with addr[1:0] != 0.
- REQ: mem_req_valid = 1, with address, data and mask stable until accepted. On mem_req_ready, go to WAIT.
- WAIT: on mem_resp_valid, go to DONE.
  - Loads: select the byte/halfword at addr[1:0]/addr[1], then extend. lb/lh sign-extend; lbu/lhu zero-extend; lw passes the whole word.
  - Stores: the acknowledge is required; rdata is ignored and out_result = valE.
- Store lane rules:
  - sb: wmask = 4'b0001 << addr[1:0]; wdata = {4{rs2[7:0]}}.
  - sh: wmask = 4'b0011 << addr[1:0]; wdata = {2{rs2[15:0]}}.
  - sw: wmask = 4'b1111; wdata = rs2.
  - Loads: wmask = 0, wen = 0.
- DONE: out_valid = 1. On out_ready, go to IDLE.
- Mixed or illegal one-hot encodings: if more than one load bit is set, or both a load and a store bit, handle as no memory op (passthrough).
- Reset mid-transaction aborts the transaction. Any response that arrives after reset is ignored (the FSM is in IDLE).

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from in_* to out_* or to mem_*.
- Latency:
  - Non-memory op: accept at edge N, out_valid from N+1.
  - Memory op: accepted edge N, REQ in cycle N+1. With ready = 1 and a response the next cycle, out_valid from N+3.
- mem_resp_valid is sampled only in WAIT. A response in the same cycle as req acceptance is not supported; the memory must answer no earlier than one cycle after acceptance.
- out_* remain stable while out_valid = 1 and out_ready = 0.
- Throughput: one instruction per at least 2 cycles (the IDLE/DONE turnaround). in_ready = 0 in REQ, WAIT and DONE.

## Test plan
- ALU passthrough: valE = 0x1234_5678, no memory op, need_dst = 1 -> out_valid one cycle after accept, out_result = 0x1234_5678, no mem_req_valid.
- lb sign extend: addr = 0x8000_0003, rdata = 0x80FF_0011 -> out_result = 0xFFFF_FF80. The same access with lbu -> 0x0000_0080.
- sh at addr 0x8000_0002, rs2 = 0xAAAA_BEEF -> wmask = 4'b1100, wdata = 0xBEEF_BEEF, wen = 1, req addr = 0x8000_0000. After the ack: out_result = 0x8000_0002.
- Backpressure:
  - mem_req_ready low for 3 cycles -> mem_req_valid held, fields unchanged.
  - out_ready low for 2 cycles -> out_result stable.
  - in_ready = 0 throughout.
- Misaligned lw at addr 0x8000_0001 -> no request, out_misalign = 1, out_need_dst = 0, out_valid next cycle.
- Reset asserted in WAIT -> all outputs 0 and in_ready = 1 immediately. A later mem_resp_valid produces no out_valid.

Source files
------------

// File: rtl/ysyx_25050141_mem_stage_if.sv
// Handshake bundles around the ME stage: execute-side input, data-memory port
// and write-back output. The stage takes ex.slave, mem.master and wb.master.
interface ysyx_25050141_mem_stage_ex_if #(parameter int XLEN = 32);
  logic            valid;
  logic            ready;
  logic [XLEN-1:0] val_e;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      load_op;
  logic [2:0]      store_op;
  logic            need_dst;
  logic            sel_reg;

  modport master (output valid, val_e, rs2_data, load_op, store_op, need_dst, sel_reg,
                  input  ready);
  modport slave  (input  valid, val_e, rs2_data, load_op, store_op, need_dst, sel_reg,
                  output ready);
endinterface

interface ysyx_25050141_mem_stage_mem_if #(parameter int XLEN = 32);
  logic            req_valid;
  logic            req_ready;
  logic            req_wen;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [3:0]      req_wmask;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;

  modport master (output req_valid, req_wen, req_addr, req_wdata, req_wmask,
                  input  req_ready, resp_valid, resp_rdata);
  modport slave  (input  req_valid, req_wen, req_addr, req_wdata, req_wmask,
                  output req_ready, resp_valid, resp_rdata);
endinterface

interface ysyx_25050141_mem_stage_wb_if #(parameter int XLEN = 32);
  logic            valid;
  logic            ready;
  logic [XLEN-1:0] result;
  logic            need_dst;
  logic            misalign;

  modport master (output valid, result, need_dst, misalign, input ready);
  modport slave  (input  valid, result, need_dst, misalign, output ready);
endinterface

// File: rtl/ysyx_25050141_mem_stage.sv
// ME stage: S_IDLE accept | S_REQ drive memory request | S_WAIT await response
// | S_DONE hold result for write-back. Single outstanding aligned access.
module ysyx_25050141_mem_stage #(
  parameter int XLEN = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  ysyx_25050141_mem_stage_ex_if.slave  ex,
  ysyx_25050141_mem_stage_mem_if.master mem,
  ysyx_25050141_mem_stage_wb_if.master  wb
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic            accept;
  logic            ld_any;
  logic            st_any;
  logic            ld_one;
  logic            st_one;
  logic            is_load;
  logic            is_store;
  logic            mem_op;
  logic            is_half;
  logic            is_word;
  logic            misal;
  logic [3:0]      st_mask;
  logic [XLEN-1:0] st_data;

  logic [4:0]      ld_q;
  logic            sel_q;
  logic [1:0]      addr_lo_q;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [XLEN-1:0] load_data;

  assign accept = (state_q == S_IDLE) && ex.valid;

  // Any encoding that is not exactly one load or one store bit is a passthrough.
  assign ld_any   = |ex.load_op;
  assign st_any   = |ex.store_op;
  assign ld_one   = ($countones(ex.load_op) == 1);
  assign st_one   = ($countones(ex.store_op) == 1);
  assign is_load  = ld_one && !st_any;
  assign is_store = st_one && !ld_any;
  assign mem_op   = is_load || is_store;

  assign is_half = is_load ? (ex.load_op[1] | ex.load_op[4]) : ex.store_op[1];
  assign is_word = is_load ? ex.load_op[2] : ex.store_op[2];
  assign misal   = mem_op && ((is_half && ex.val_e[0]) ||
                              (is_word && (ex.val_e[1:0] != 2'b00)));

  always_comb begin
    st_mask = 4'b0000;
    st_data = ex.rs2_data;
    if (ex.store_op[0]) begin
      st_mask = 4'b0001 << ex.val_e[1:0];
      st_data = {4{ex.rs2_data[7:0]}};
    end else if (ex.store_op[1]) begin
      st_mask = 4'b0011 << ex.val_e[1:0];
      st_data = {2{ex.rs2_data[15:0]}};
    end else if (ex.store_op[2]) begin
      st_mask = 4'b1111;
    end
  end

  always_comb begin
    case (addr_lo_q)
      2'd0:    rd_byte = mem.resp_rdata[7:0];
      2'd1:    rd_byte = mem.resp_rdata[15:8];
      2'd2:    rd_byte = mem.resp_rdata[23:16];
      default: rd_byte = mem.resp_rdata[31:24];
    endcase
  end

  assign rd_half = addr_lo_q[1] ? mem.resp_rdata[31:16] : mem.resp_rdata[15:0];

  always_comb begin
    load_data = mem.resp_rdata;
    if (ld_q[0])      load_data = {{24{rd_byte[7]}}, rd_byte};
    else if (ld_q[1]) load_data = {{16{rd_half[15]}}, rd_half};
    else if (ld_q[3]) load_data = {24'd0, rd_byte};
    else if (ld_q[4]) load_data = {16'd0, rd_half};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (ex.valid)      state_d = (mem_op && !misal) ? S_REQ : S_DONE;
      S_REQ:  if (mem.req_ready) state_d = S_WAIT;
      S_WAIT: if (mem.resp_valid) state_d = S_DONE;
      S_DONE: if (wb.ready)      state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  assign ex.ready      = (state_q == S_IDLE);
  assign mem.req_valid = (state_q == S_REQ);
  assign wb.valid      = (state_q == S_DONE);

  // Request fields and the default result are fixed at accept, so they stay
  // stable through request and write-back backpressure.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem.req_addr  <= '0;
      mem.req_wen   <= 1'b0;
      mem.req_wmask <= 4'b0000;
      mem.req_wdata <= '0;
      ld_q          <= 5'd0;
      sel_q         <= 1'b0;
      addr_lo_q     <= 2'd0;
      wb.result     <= '0;
      wb.need_dst   <= 1'b0;
      wb.misalign   <= 1'b0;
    end else if (accept) begin
      mem.req_addr  <= {ex.val_e[XLEN-1:2], 2'b00};
      mem.req_wen   <= is_store && !misal;
      mem.req_wmask <= (is_store && !misal) ? st_mask : 4'b0000;
      mem.req_wdata <= (is_store && !misal) ? st_data : '0;
      ld_q          <= (is_load && !misal) ? ex.load_op : 5'd0;
      sel_q         <= ex.sel_reg;
      addr_lo_q     <= ex.val_e[1:0];
      wb.result     <= ex.val_e;
      wb.need_dst   <= ex.need_dst && !misal;
      wb.misalign   <= misal;
    end else if ((state_q == S_WAIT) && mem.resp_valid && (|ld_q) && sel_q) begin
      wb.result <= load_data;
    end
  end

endmodule

// File: tb/tb_ysyx_25050141_mem_stage.sv
// Bench for the ME stage: directed scenarios plus randomized transactions
// checked against an arithmetic reference model of the load/store rules.
module tb_ysyx_25050141_mem_stage;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ysyx_25050141_mem_stage_ex_if  #(.XLEN(32)) ex_bus ();
  ysyx_25050141_mem_stage_mem_if #(.XLEN(32)) mem_bus ();
  ysyx_25050141_mem_stage_wb_if  #(.XLEN(32)) wb_bus ();

  ysyx_25050141_mem_stage #(.XLEN(32)) dut (
    .clock (clock),
    .reset (reset),
    .ex    (ex_bus),
    .mem   (mem_bus),
    .wb    (wb_bus)
  );

  int checks = 0;
  int errors = 0;

  // observations of the last transaction
  bit          o_timeout, o_saw_req, o_req_unstable, o_out_unstable, o_ready_leak;
  int          o_lat, o_req_cycles;
  logic [31:0] o_addr, o_wdata, o_result;
  logic [3:0]  o_wmask;
  logic        o_wen, o_need, o_mis;

  // reference model outputs
  bit          m_memop, m_mis, m_wen, m_need;
  logic [31:0] m_addr, m_wdata, m_result;
  logic [3:0]  m_wmask;

  task automatic ref_model(input logic [31:0] v, input logic [31:0] rs2,
                           input logic [4:0] ld, input logic [2:0] st,
                           input logic need, input logic sel, input logic [31:0] rdata);
    int nl, ns, size, a;
    logic [31:0] lane, x;
    nl = $countones(ld);
    ns = $countones(st);
    m_memop = ((nl + ns) == 1);
    size = (ld[0] | ld[3] | st[0]) ? 1 : ((ld[1] | ld[4] | st[1]) ? 2 : 4);
    a = int'(v[1:0]);
    m_mis = m_memop && ((a % size) != 0);
    m_addr = v - 32'(a);
    m_wen = m_memop && !m_mis && (ns == 1);
    m_wmask = m_wen ? 4'(((1 << size) - 1) << a) : 4'b0000;
    if (size == 1)      m_wdata = 32'(rs2[7:0]) * 32'h0101_0101;
    else if (size == 2) m_wdata = 32'(rs2[15:0]) * 32'h0001_0001;
    else                m_wdata = rs2;
    if (m_memop && !m_mis && (nl == 1) && sel) begin
      lane = rdata >> (8 * a);
      if (size == 1) begin
        x = lane & 32'hFF;
        if (ld[0] && (x >= 32'd128)) x = x - 32'd256;
      end else if (size == 2) begin
        x = lane & 32'hFFFF;
        if (ld[1] && (x >= 32'h8000)) x = x - 32'h1_0000;
      end else begin
        x = rdata;
      end
      m_result = x;
    end else begin
      m_result = v;
    end
    m_need = need && !m_mis;
  endtask

  // Drives one transaction from IDLE (entered and left at a falling edge) and
  // records what the DUT did; callers compare the observations.
  task automatic do_txn(input logic [31:0] v, input logic [31:0] rs2,
                        input logic [4:0] ld, input logic [2:0] st,
                        input logic need, input logic sel, input logic [31:0] rdata,
                        input int req_stall, input int out_stall);
    int cyc, req_n, out_n;
    bit rdy_drv, done;
    cyc = 0; req_n = 0; out_n = 0; rdy_drv = 0; done = 0;
    o_saw_req = 0; o_req_unstable = 0; o_out_unstable = 0; o_ready_leak = 0;
    o_lat = -1; o_req_cycles = 0;
    ex_bus.valid = 1'b1; ex_bus.val_e = v; ex_bus.rs2_data = rs2;
    ex_bus.load_op = ld; ex_bus.store_op = st; ex_bus.need_dst = need; ex_bus.sel_reg = sel;
    while (!done && cyc < 60) begin
      @(negedge clock);
      ex_bus.valid = 1'b0;
      cyc++;
      mem_bus.resp_valid = 1'b0;
      mem_bus.resp_rdata = $urandom;
      if (ex_bus.ready !== 1'b0) o_ready_leak = 1;
      if (rdy_drv) begin
        rdy_drv = 0;
        mem_bus.req_ready = 1'b0;
        mem_bus.resp_valid = 1'b1;
        mem_bus.resp_rdata = rdata;
      end else if (mem_bus.req_valid === 1'b1) begin
        o_saw_req = 1;
        req_n++;
        if (req_n == 1) begin
          o_addr = mem_bus.req_addr; o_wen = mem_bus.req_wen;
          o_wmask = mem_bus.req_wmask; o_wdata = mem_bus.req_wdata;
        end else if ({o_addr, o_wen, o_wmask, o_wdata} !==
                     {mem_bus.req_addr, mem_bus.req_wen, mem_bus.req_wmask, mem_bus.req_wdata}) begin
          o_req_unstable = 1;
        end
        if (req_n > req_stall) begin
          mem_bus.req_ready = 1'b1;
          rdy_drv = 1;
        end
      end
      if (wb_bus.valid === 1'b1) begin
        out_n++;
        if (out_n == 1) begin
          o_lat = cyc; o_result = wb_bus.result;
          o_need = wb_bus.need_dst; o_mis = wb_bus.misalign;
        end else if ({o_result, o_need, o_mis} !==
                     {wb_bus.result, wb_bus.need_dst, wb_bus.misalign}) begin
          o_out_unstable = 1;
        end
        if (out_n > out_stall) begin
          wb_bus.ready = 1'b1;
          done = 1;
        end
      end
    end
    o_req_cycles = req_n;
    o_timeout = !done;
    @(negedge clock);
    wb_bus.ready = 1'b0;
    mem_bus.req_ready = 1'b0;
    mem_bus.resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (ex_bus.ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", ex_bus.ready);
    end
    checks++;
    if ({mem_bus.req_valid, wb_bus.valid} !== 2'b00) begin
      errors++; $display("FAIL reset_valids got %b want 00", {mem_bus.req_valid, wb_bus.valid});
    end
    checks++;
    if ({mem_bus.req_wen, mem_bus.req_addr, mem_bus.req_wdata, mem_bus.req_wmask} !== 69'd0) begin
      errors++; $display("FAIL reset_req_fields got %h want 0",
                         {mem_bus.req_wen, mem_bus.req_addr, mem_bus.req_wdata, mem_bus.req_wmask});
    end
    checks++;
    if ({wb_bus.result, wb_bus.need_dst, wb_bus.misalign} !== 34'd0) begin
      errors++; $display("FAIL reset_out_fields got %h want 0",
                         {wb_bus.result, wb_bus.need_dst, wb_bus.misalign});
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_passthrough();
    do_txn(32'h1234_5678, 32'h0, 5'b0, 3'b0, 1'b1, 1'b0, 32'h0, 0, 0);
    checks++;
    if (o_timeout || o_lat != 1) begin
      errors++; $display("FAIL pass_latency got %0d want 1", o_lat);
    end
    checks++;
    if (o_result !== 32'h1234_5678) begin
      errors++; $display("FAIL pass_result got %h want 12345678", o_result);
    end
    checks++;
    if (o_saw_req) begin
      errors++; $display("FAIL pass_no_req got req want none");
    end
    checks++;
    if ({o_need, o_mis} !== 2'b10) begin
      errors++; $display("FAIL pass_flags got %b want 10", {o_need, o_mis});
    end
  endtask

  task automatic test_load_ext();
    do_txn(32'h8000_0003, 32'h0, 5'b00001, 3'b0, 1'b1, 1'b1, 32'h80FF_0011, 0, 0);
    checks++;
    if (o_result !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL lb_result got %h want ffffff80", o_result);
    end
    checks++;
    if (o_timeout || o_lat != 3) begin
      errors++; $display("FAIL lb_latency got %0d want 3", o_lat);
    end
    checks++;
    if ({o_addr, o_wen, o_wmask} !== {32'h8000_0000, 1'b0, 4'b0000}) begin
      errors++; $display("FAIL lb_req got addr %h wen %b mask %b want 80000000 0 0000",
                         o_addr, o_wen, o_wmask);
    end
    do_txn(32'h8000_0003, 32'h0, 5'b01000, 3'b0, 1'b1, 1'b1, 32'h80FF_0011, 0, 0);
    checks++;
    if (o_result !== 32'h0000_0080) begin
      errors++; $display("FAIL lbu_result got %h want 00000080", o_result);
    end
  endtask

  task automatic test_store_sh();
    do_txn(32'h8000_0002, 32'hAAAA_BEEF, 5'b0, 3'b010, 1'b0, 1'b0, 32'h1357_9BDF, 0, 0);
    checks++;
    if ({o_wen, o_wmask} !== 5'b1_1100) begin
      errors++; $display("FAIL sh_mask got wen %b mask %b want 1 1100", o_wen, o_wmask);
    end
    checks++;
    if (o_wdata !== 32'hBEEF_BEEF) begin
      errors++; $display("FAIL sh_wdata got %h want beefbeef", o_wdata);
    end
    checks++;
    if (o_addr !== 32'h8000_0000) begin
      errors++; $display("FAIL sh_addr got %h want 80000000", o_addr);
    end
    checks++;
    if (o_timeout || o_result !== 32'h8000_0002) begin
      errors++; $display("FAIL sh_result got %h want 80000002", o_result);
    end
  endtask

  task automatic test_backpressure();
    do_txn(32'h0000_1008, 32'h0, 5'b00100, 3'b0, 1'b1, 1'b1, 32'hCAFE_F00D, 3, 2);
    checks++;
    if (o_req_unstable || o_req_cycles != 4) begin
      errors++; $display("FAIL bp_req_hold got cycles %0d unstable %0d want 4 0",
                         o_req_cycles, o_req_unstable);
    end
    checks++;
    if (o_out_unstable) begin
      errors++; $display("FAIL bp_out_stable got unstable want stable");
    end
    checks++;
    if (o_ready_leak) begin
      errors++; $display("FAIL bp_in_ready got high while busy want low");
    end
    checks++;
    if (o_timeout || o_lat != 6 || o_result !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL bp_result got lat %0d res %h want 6 cafef00d", o_lat, o_result);
    end
  endtask

  task automatic test_misalign();
    do_txn(32'h8000_0001, 32'h0, 5'b00100, 3'b0, 1'b1, 1'b1, 32'h0, 0, 0);
    checks++;
    if (o_saw_req) begin
      errors++; $display("FAIL mis_no_req got req want none");
    end
    checks++;
    if ({o_mis, o_need} !== 2'b10) begin
      errors++; $display("FAIL mis_flags got mis %b need %b want 1 0", o_mis, o_need);
    end
    checks++;
    if (o_timeout || o_lat != 1 || o_result !== 32'h8000_0001) begin
      errors++; $display("FAIL mis_result got lat %0d res %h want 1 80000001", o_lat, o_result);
    end
  endtask

  task automatic test_reset_in_wait();
    bit leaked;
    leaked = 0;
    ex_bus.valid = 1'b1; ex_bus.val_e = 32'h8000_0010; ex_bus.rs2_data = 32'h0;
    ex_bus.load_op = 5'b00100; ex_bus.store_op = 3'b0; ex_bus.need_dst = 1'b1; ex_bus.sel_reg = 1'b1;
    @(negedge clock);
    ex_bus.valid = 1'b0;
    mem_bus.req_ready = 1'b1;
    @(negedge clock);
    mem_bus.req_ready = 1'b0;
    checks++;
    if ({ex_bus.ready, mem_bus.req_valid, wb_bus.valid} !== 3'b000) begin
      errors++; $display("FAIL rst_wait_state got %b want 000",
                         {ex_bus.ready, mem_bus.req_valid, wb_bus.valid});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({ex_bus.ready, mem_bus.req_valid, wb_bus.valid} !== 3'b100) begin
      errors++; $display("FAIL rst_wait_handshake got %b want 100",
                         {ex_bus.ready, mem_bus.req_valid, wb_bus.valid});
    end
    checks++;
    if ({mem_bus.req_addr, mem_bus.req_wen, wb_bus.result, wb_bus.need_dst, wb_bus.misalign} !== 67'd0) begin
      errors++; $display("FAIL rst_wait_fields got %h want 0",
                         {mem_bus.req_addr, mem_bus.req_wen, wb_bus.result, wb_bus.need_dst, wb_bus.misalign});
    end
    @(negedge clock);
    reset = 1'b0;
    mem_bus.resp_valid = 1'b1;
    mem_bus.resp_rdata = 32'h5555_AAAA;
    @(negedge clock);
    mem_bus.resp_valid = 1'b0;
    repeat (3) begin
      if (wb_bus.valid !== 1'b0) leaked = 1;
      @(negedge clock);
    end
    checks++;
    if (leaked || ex_bus.ready !== 1'b1) begin
      errors++; $display("FAIL rst_late_resp got out_valid %0d in_ready %b want 0 1",
                         leaked, ex_bus.ready);
    end
  endtask

  task automatic test_random(input int n);
    logic [31:0] v, rs2, rdata;
    logic [4:0]  ld;
    logic [2:0]  st;
    logic        need, sel;
    int kind, i0, j0, rs, os, exp_lat;
    for (int t = 0; t < n; t++) begin
      v = $urandom; rs2 = $urandom; rdata = $urandom;
      need = 1'($urandom_range(0, 1));
      sel = ($urandom_range(0, 3) != 0);
      ld = 5'b0; st = 3'b0;
      kind = $urandom_range(0, 9);
      i0 = $urandom_range(0, 4);
      j0 = (i0 + 1 + $urandom_range(0, 3)) % 5;
      if (kind >= 2 && kind <= 5) ld[i0] = 1'b1;
      else if (kind == 6 || kind == 7) st[$urandom_range(0, 2)] = 1'b1;
      else if (kind == 8) begin ld[i0] = 1'b1; ld[j0] = 1'b1; end
      else if (kind == 9) begin ld[i0] = 1'b1; st[$urandom_range(0, 2)] = 1'b1; end
      rs = $urandom_range(0, 2);
      os = $urandom_range(0, 2);
      ref_model(v, rs2, ld, st, need, sel, rdata);
      exp_lat = (m_memop && !m_mis) ? 3 + rs : 1;
      do_txn(v, rs2, ld, st, need, sel, rdata, rs, os);
      checks++;
      if (o_timeout || o_lat != exp_lat) begin
        errors++; $display("FAIL rnd%0d_latency got %0d want %0d", t, o_lat, exp_lat);
      end
      checks++;
      if ({o_result, o_need, o_mis} !== {m_result, m_need, m_mis}) begin
        errors++; $display("FAIL rnd%0d_out got %h/%b/%b want %h/%b/%b (ld %b st %b v %h rd %h)",
                           t, o_result, o_need, o_mis, m_result, m_need, m_mis, ld, st, v, rdata);
      end
      checks++;
      if (o_saw_req != (m_memop && !m_mis)) begin
        errors++; $display("FAIL rnd%0d_req_present got %0d want %0d", t, o_saw_req, m_memop && !m_mis);
      end
      if (m_memop && !m_mis) begin
        checks++;
        if ({o_addr, o_wen, o_wmask} !== {m_addr, m_wen, m_wmask}) begin
          errors++; $display("FAIL rnd%0d_req got %h/%b/%b want %h/%b/%b",
                             t, o_addr, o_wen, o_wmask, m_addr, m_wen, m_wmask);
        end
        if (m_wen) begin
          checks++;
          if (o_wdata !== m_wdata) begin
            errors++; $display("FAIL rnd%0d_wdata got %h want %h", t, o_wdata, m_wdata);
          end
        end
      end
      checks++;
      if (o_req_unstable || o_out_unstable || o_ready_leak || ex_bus.ready !== 1'b1) begin
        errors++; $display("FAIL rnd%0d_handshake got req_unst %0d out_unst %0d leak %0d in_ready %b want 0 0 0 1",
                           t, o_req_unstable, o_out_unstable, o_ready_leak, ex_bus.ready);
      end
    end
  endtask

  initial begin
    ex_bus.valid = 1'b0; ex_bus.val_e = '0; ex_bus.rs2_data = '0;
    ex_bus.load_op = '0; ex_bus.store_op = '0; ex_bus.need_dst = 1'b0; ex_bus.sel_reg = 1'b0;
    mem_bus.req_ready = 1'b0; mem_bus.resp_valid = 1'b0; mem_bus.resp_rdata = '0;
    wb_bus.ready = 1'b0;
    test_reset();
    test_passthrough();
    test_load_ext();
    test_store_sh();
    test_backpressure();
    test_misalign();
    test_reset_in_wait();
    test_random(200);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
